rate_step_scheduler: RTL

Programmable sequencer that owns a rate divider and the 4-bit display counter it enables. It runs a short program of up to four steps. Each step sets a tick rate (speed code) and a number of ticks, and the block steps through them without CPU or switch intervention. It sits between the board switches/keys (program load, Start, Abort) and the HEX display driver, which consumes CounterValue.

---
 rtl/rate_step_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rate_step_scheduler.sv
// -----------------------------------------------------------------------------
// rate_step_scheduler
//
// Runs a short program of up to four steps. Each step selects a tick rate and
// a number of ticks. The block owns the rate divider and the 4-bit display
// counter that the divider advances, so it needs no CPU or switch activity
// while the program runs.
//
// Parameters
//   CYCLES_PER_UNIT  clock cycles in one base tick period P
//
// Ports
//   ClockIn       in   1  system clock; all state changes on its rising edge
//   Reset         in   1  synchronous, active-high reset
//   WrEn          in   1  program-table write strobe (ignored while Busy)
//   WrAddr        in   2  step index written
//   WrData        in   6  step word: [5:4] speed code, [3:0] tick count LEN
//   Start         in   1  begin program at step 0 (level, sampled in IDLE)
//   Abort         in   1  stop program immediately (beats Start and ticks)
//   Loop          in   1  latched with Start; 1 = repeat program forever
//   CounterValue  out  4  display count, +1 on every tick, wraps 15 -> 0
//   StepIdx       out  2  step currently executing
//   Tick          out  1  one-cycle pulse per divider expiry
//   Busy          out  1  high in LOAD and RUN
//   Done          out  1  one-cycle pulse at normal program end
//   DebugState    out  2  current FSM state encoding, for checkers
//
// Handshake: there is no valid/ready pair. Start is a level that is accepted
// only in IDLE with Abort low; WrEn is a strobe that is accepted only while
// Busy is low. Anything presented outside those windows is dropped.
//
// Speed code to period (cycles between ticks):
//   00 -> 1, 01 -> P, 10 -> 2P, 11 -> 4P
// LEN = 0 marks the end of the program.
// -----------------------------------------------------------------------------
module rate_step_scheduler #(
  parameter int unsigned CYCLES_PER_UNIT = 50000000
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       WrEn,
  input  logic [1:0] WrAddr,
  input  logic [5:0] WrData,
  input  logic       Start,
  input  logic       Abort,
  input  logic       Loop,
  output logic [3:0] CounterValue,
  output logic [1:0] StepIdx,
  output logic       Tick,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] DebugState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] UNIT = 32'(CYCLES_PER_UNIT);

  // Divider reload value (period - 1) for a speed code.
  function automatic logic [31:0] reload_of(input logic [1:0] code);
    logic [31:0] period;
    case (code)
      2'b00:   period = 32'd1;
      2'b01:   period = UNIT;
      2'b10:   period = UNIT << 1;
      default: period = UNIT << 2;
    endcase
    return period - 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [5:0]  table_q [4];
  logic [31:0] div_q;
  logic [3:0]  count_q;      // display counter
  logic [3:0]  step_cnt_q;   // ticks completed in the current step
  logic [1:0]  step_q;
  logic        loop_q;

  // ---------------------------------------------------------------------------
  // Next-step decode, used on the tick that completes a step
  // ---------------------------------------------------------------------------
  logic [3:0]  cur_len;
  logic [3:0]  step_cnt_d;
  logic        step_end;
  logic [1:0]  next_idx_d;
  logic        wrap_past_last;
  logic        next_empty;
  logic        entry0_empty;
  logic        prog_end;
  logic        tick_now;
  logic        busy_now;
  logic [31:0] cur_reload;

  always_comb begin
    cur_len        = table_q[step_q][3:0];
    cur_reload     = reload_of(table_q[step_q][5:4]);
    step_cnt_d     = step_cnt_q + 4'd1;
    step_end       = (step_cnt_d == cur_len);
    next_idx_d     = step_q + 2'd1;          // 3 + 1 wraps naturally to 0
    wrap_past_last = (step_q == 2'd3);
    next_empty     = (table_q[next_idx_d][3:0] == 4'd0);
    entry0_empty   = (table_q[0][3:0] == 4'd0);
    // The program ends (or loops) after the last slot or at an empty slot.
    prog_end       = wrap_past_last || next_empty;
    tick_now       = (state_q == S_RUN) && (div_q == 32'd0);
    busy_now       = (state_q == S_LOAD) || (state_q == S_RUN);
  end

  // ---------------------------------------------------------------------------
  // FSM, divider, counters and program table
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      count_q    <= '0;
      step_cnt_q <= '0;
      step_q     <= '0;
      loop_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      // Table writes are locked out while a program is executing so the
      // running program cannot be changed underneath itself.
      if (WrEn && !busy_now) begin
        table_q[WrAddr] <= WrData;
      end

      case (state_q)
        S_IDLE: begin
          if (Start && !Abort) begin
            step_q  <= '0;
            count_q <= '0;
            loop_q  <= Loop;
            state_q <= entry0_empty ? S_DONE : S_LOAD;
          end
        end

        S_LOAD: begin
          if (Abort) begin
            step_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            div_q      <= cur_reload;
            step_cnt_q <= '0;
            state_q    <= S_RUN;
          end
        end

        S_RUN: begin
          if (Abort) begin
            // Abort wins over a coincident tick: no increment, no Done.
            step_q  <= '0;
            state_q <= S_IDLE;
          end else if (tick_now) begin
            div_q      <= cur_reload;
            count_q    <= count_q + 4'd1;
            step_cnt_q <= step_cnt_d;
            if (step_end) begin
              if (prog_end) begin
                if (loop_q && !entry0_empty) begin
                  step_q  <= '0;
                  state_q <= S_LOAD;
                end else begin
                  state_q <= S_DONE;
                end
              end else begin
                step_q  <= next_idx_d;
                state_q <= S_LOAD;
              end
            end
          end else begin
            div_q <= div_q - 32'd1;
          end
        end

        S_DONE: begin
          // Start is not looked at here; it is accepted again from IDLE.
          step_q  <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state only
  // ---------------------------------------------------------------------------
  assign CounterValue = count_q;
  assign StepIdx      = step_q;
  assign Tick         = tick_now;
  assign Busy         = busy_now;
  assign Done         = (state_q == S_DONE);
  assign DebugState   = state_q;

endmodule
